decode_block: RTL and testbench
===============================

DECODE_BLOCK -- requirements
Module: decode_block

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port ins, input, 32 bits: instruction from the program memory stage, valid the cycle after its address.
REQ-004 SHALL have port current_address, input, 16 bits: fetch address from the program memory stage.
REQ-005 SHALL have ports wb_en (1 bit), wb_addr (5 bits) and wb_data (32 bits), inputs: register-file write port.
REQ-006 SHALL have ports mem_reg_write (1 bit) and mem_dest (5 bits), inputs: destination of the instruction in the MEM stage.
REQ-007 SHALL have ports stall, stall_pm and pc_mux_sel, outputs, 1 bit each, combinational: control to the program memory stage.
REQ-008 SHALL have port jmp_loc, output, 16 bits, combinational: redirect target.
REQ-009 SHALL have registered ID/EX outputs: ex_rs_data (32 bits), ex_rt_data (32 bits), ex_imm (32 bits), ex_dest (5 bits), ex_alu_op (3 bits), ex_reg_write, ex_mem_read, ex_mem_write and ex_valid (1 bit each).

Function
REQ-010 SHALL register current_address each unstalled cycle as pc_d, the address of the instruction currently on ins.
REQ-011 SHALL decode these instructions:
- R-type, opcode 0x00: funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
- ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
- Any other opcode or funct is a NOP, so all-zero ins decodes as NOP.
REQ-012 SHALL encode ex_alu_op as ADD=000, SUB=001, AND=010, OR=011, SLT=100.
- ADDI, LW and SW use ADD.
- BEQ, J and NOP drive 000 with no control asserted.
REQ-013 SHALL drive ex_dest as rd for R-type and rt for ADDI and LW; reg_write SHALL be 0 for SW, BEQ, J and NOP.
REQ-014 SHALL sign-extend ins[15:0] to 32 bits for ex_imm.
REQ-015 SHALL hold a 32x32 register file in which r0 reads 0 and writes to r0 are ignored.
REQ-016 SHALL write the register file on the clock edge when wb_en=1, and a same-cycle read of wb_addr SHALL return wb_data (bypass).
REQ-017 SHALL detect a load-use hazard when all of the following hold:
- ex_mem_read=1 and ex_dest!=0;
- ex_dest equals rs, or equals rt for an R-type, SW or BEQ instruction.
REQ-018 SHALL detect a branch hazard when BEQ's rs or rt (nonzero) equals ex_dest with ex_reg_write=1, or equals mem_dest with mem_reg_write=1.
REQ-019 SHALL, on any hazard:
- assert stall=1 and stall_pm=1;
- force pc_mux_sel=0;
- load a bubble into ID/EX (all controls 0, ex_valid=0);
- hold pc_d.
REQ-020 SHALL resolve jumps when no hazard is present:
- J: pc_mux_sel=1, jmp_loc=ins[15:0].
- BEQ with rs_data==rt_data: pc_mux_sel=1, jmp_loc=pc_d+1+ins[15:0], modulo 2^16.
- Otherwise: pc_mux_sel=0, jmp_loc=0.
REQ-021 SHALL flush nothing on a redirect, because the target is fetched directly through current_address and arrives on the next cycle.
REQ-022 SHALL take 1 cycle from ins to the ID/EX outputs, with ex_valid=1 for a non-NOP, non-bubble instruction.
REQ-023 SHALL give stall priority over redirect when a stall and a redirect condition coincide.

Reset
REQ-024 SHALL, while reset=0, clear all ID/EX outputs, pc_d and all registers to 0, and hold stall, stall_pm and pc_mux_sel at 0.
REQ-025 SHALL, on reset asserted mid-stall, drop the stall in the same cycle; the first post-reset ins (0) SHALL decode as NOP.

Structure
REQ-026 SHALL place opcode and funct constants, the ALU op encoding and the ID/EX field widths in the shared package decode_pkg.
REQ-027 SHALL implement the register file as the sub-module reg_file (two read ports, one write port, bypass, async clear).

Verification
REQ-028 The bench SHALL cover ADDI r1,r0,5, then wb writes r1=5, then ADD r2,r1,r1 -> ex_alu_op=000, ex_rs_data=ex_rt_data=5, ex_dest=2, ex_reg_write=1.
REQ-029 The bench SHALL cover LW r3 followed by ADD r4,r3,r1 -> stall=stall_pm=1 for exactly 1 cycle, one bubble (ex_valid=0), then ADD issues.
REQ-030 The bench SHALL cover J 0x0040 at pc_d=0x0010 -> pc_mux_sel=1 and jmp_loc=0x0040 in that cycle, and the next ins decoded has pc_d=0x0040.
REQ-031 The bench SHALL cover BEQ r0,r0,0xFFFE at pc_d=0x0005 -> jmp_loc=0x0004; BEQ on unequal operands -> pc_mux_sel=0.
REQ-032 The bench SHALL cover BEQ r5 with mem_dest=5 and mem_reg_write=1 -> stall held until the match clears, pc_mux_sel=0 throughout, then the branch resolves.
REQ-033 The bench SHALL cover reset=0 asserted during a load-use stall -> all outputs 0 immediately, and a read of r1 after release returns 0.

Source files
------------

// File: rtl/decode_block_pkg.sv
// Shared decode constants, ALU encoding and ID/EX pipeline record.
// Imported by the interface, the register file and the decode stage.
package decode_pkg;

   localparam int unsigned INS_W  = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned ALU_W  = 3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_e;

   typedef enum logic [2:0] {
      K_NOP, K_RTYPE, K_ADDI, K_LW, K_SW, K_BEQ, K_J
   } ins_kind_e;

   typedef struct packed {
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] dest;
      alu_op_e           alu_op;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              valid;
   } idex_t;

   function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/decode_block_if.sv
// ID/EX pipeline bus between the decode stage (master) and execute (slave).
interface decode_block_if;
   import decode_pkg::*;

   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [REG_AW-1:0] ex_dest;
   logic [ALU_W-1:0]  ex_alu_op;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_valid;

   modport master (
      output ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_alu_op,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_valid
   );

   modport slave (
      input  ex_rs_data, ex_rt_data, ex_imm, ex_dest, ex_alu_op,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_valid
   );

endinterface

// File: rtl/decode_block_reg_file.sv
// 32x32 register file: two async read ports with write bypass, one write
// port, r0 hardwired to zero, asynchronous active-low clear.
module reg_file
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [32];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a = regs[raddr_a];
      if (raddr_a == '0)                    rdata_a = '0;
      else if (we && (waddr == raddr_a))    rdata_a = wdata;
   end

   always_comb begin
      rdata_b = regs[raddr_b];
      if (raddr_b == '0)                    rdata_b = '0;
      else if (we && (waddr == raddr_b))    rdata_b = wdata;
   end

endmodule

// File: rtl/decode_block.sv
// Instruction decode stage: decode, register read, hazard detection,
// branch/jump resolution and the ID/EX pipeline register.
module decode_block
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [INS_W-1:0]  ins,
   input  logic [ADDR_W-1:0] current_address,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_dest,
   output logic              stall,
   output logic              stall_pm,
   output logic              pc_mux_sel,
   output logic [ADDR_W-1:0] jmp_loc,
   decode_block_if.master    ex
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [DATA_W-1:0] rs_data, rt_data;
   logic [ADDR_W-1:0] pc_d;
   ins_kind_e         kind;
   alu_op_e           r_alu;
   idex_t             dec;
   idex_t             idex_q;
   logic              uses_rt, load_use, branch_hz, hazard, taken;

   assign opcode = ins[31:26];
   assign rs     = ins[25:21];
   assign rt     = ins[20:16];
   assign rd     = ins[15:11];
   assign funct  = ins[5:0];

   reg_file u_reg_file (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (rs),
      .rdata_a (rs_data),
      .raddr_b (rt),
      .rdata_b (rt_data)
   );

   always_comb begin
      kind  = K_NOP;
      r_alu = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            kind = K_RTYPE;
            case (funct)
               FN_ADD:  r_alu = ALU_ADD;
               FN_SUB:  r_alu = ALU_SUB;
               FN_AND:  r_alu = ALU_AND;
               FN_OR:   r_alu = ALU_OR;
               FN_SLT:  r_alu = ALU_SLT;
               default: kind  = K_NOP;
            endcase
         end
         OP_ADDI: kind = K_ADDI;
         OP_LW:   kind = K_LW;
         OP_SW:   kind = K_SW;
         OP_BEQ:  kind = K_BEQ;
         OP_J:    kind = K_J;
         default: kind = K_NOP;
      endcase
   end

   always_comb begin
      dec         = '0;
      dec.rs_data = rs_data;
      dec.rt_data = rt_data;
      dec.imm     = sign_ext16(ins[15:0]);
      dec.alu_op  = ALU_ADD;
      case (kind)
         K_RTYPE: begin
            dec.dest      = rd;
            dec.alu_op    = r_alu;
            dec.reg_write = 1'b1;
            dec.valid     = 1'b1;
         end
         K_ADDI: begin
            dec.dest      = rt;
            dec.reg_write = 1'b1;
            dec.valid     = 1'b1;
         end
         K_LW: begin
            dec.dest      = rt;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            dec.valid     = 1'b1;
         end
         K_SW: begin
            dec.mem_write = 1'b1;
            dec.valid     = 1'b1;
         end
         K_BEQ, K_J: dec.valid = 1'b1;
         default: ;
      endcase
   end

   // A BEQ source is busy while an older in-flight writer still targets it.
   function automatic logic src_busy(
      input logic [REG_AW-1:0] src,
      input logic              ex_wr,
      input logic [REG_AW-1:0] ex_dst,
      input logic              mem_wr,
      input logic [REG_AW-1:0] mem_dst
   );
      return (src != '0) && ((ex_wr && (src == ex_dst)) || (mem_wr && (src == mem_dst)));
   endfunction

   always_comb begin
      uses_rt   = (kind == K_RTYPE) || (kind == K_SW) || (kind == K_BEQ);
      load_use  = idex_q.mem_read && (idex_q.dest != '0) &&
                  ((idex_q.dest == rs) || (uses_rt && (idex_q.dest == rt)));
      branch_hz = (kind == K_BEQ) &&
                  (src_busy(rs, idex_q.reg_write, idex_q.dest, mem_reg_write, mem_dest) ||
                   src_busy(rt, idex_q.reg_write, idex_q.dest, mem_reg_write, mem_dest));
   end

   // Gating with reset drops a pending stall the moment reset asserts.
   assign hazard     = reset && (load_use || branch_hz);
   assign stall      = hazard;
   assign stall_pm   = hazard;
   assign taken      = reset && !hazard &&
                       ((kind == K_J) || ((kind == K_BEQ) && (rs_data == rt_data)));
   assign pc_mux_sel = taken;

   always_comb begin
      jmp_loc = '0;
      if (taken) begin
         if (kind == K_J) jmp_loc = ins[15:0];
         else             jmp_loc = pc_d + 16'd1 + ins[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idex_q <= '0;
         pc_d   <= '0;
      end else if (hazard) begin
         idex_q <= '0;
      end else begin
         idex_q <= dec;
         pc_d   <= current_address;
      end
   end

   assign ex.ex_rs_data   = idex_q.rs_data;
   assign ex.ex_rt_data   = idex_q.rt_data;
   assign ex.ex_imm       = idex_q.imm;
   assign ex.ex_dest      = idex_q.dest;
   assign ex.ex_alu_op    = idex_q.alu_op;
   assign ex.ex_reg_write = idex_q.reg_write;
   assign ex.ex_mem_read  = idex_q.mem_read;
   assign ex.ex_mem_write = idex_q.mem_write;
   assign ex.ex_valid     = idex_q.valid;

endmodule

// File: tb/tb_decode_block.sv
// Scoreboard bench for decode_block: a reference model predicts each cycle's
// control outputs and the ID/EX record; two monitors compare DUT outputs.
module tb_decode_block;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ins = '0;
   logic [15:0] current_address = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        mem_reg_write = 1'b0;
   logic [4:0]  mem_dest = '0;
   logic        stall, stall_pm, pc_mux_sel;
   logic [15:0] jmp_loc;

   always #5 clk = ~clk;

   decode_block_if ex_if ();

   decode_block dut (
      .clk             (clk),
      .reset           (reset),
      .ins             (ins),
      .current_address (current_address),
      .wb_en           (wb_en),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data),
      .mem_reg_write   (mem_reg_write),
      .mem_dest        (mem_dest),
      .stall           (stall),
      .stall_pm        (stall_pm),
      .pc_mux_sel      (pc_mux_sel),
      .jmp_loc         (jmp_loc),
      .ex              (ex_if)
   );

   typedef struct packed { logic stall; logic pcsel; logic [15:0] jmp; } comb_t;
   typedef struct packed {
      logic [31:0] rs, rt, imm;
      logic [4:0]  dest;
      logic [2:0]  op;
      logic        rw, mr, mw, v;
   } pkt_t;

   comb_t       cq[$];
   pkt_t        xq[$];
   logic [31:0] m_regs [32];
   logic [15:0] m_pcd = '0;
   logic [15:0] pm_pc = '0;
   pkt_t        m_ex = '0;
   logic        m_last_stall = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] fn);
      return {6'h00, s, t, d, 5'h00, fn};
   endfunction
   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction
   function automatic logic [31:0] jtype(input logic [15:0] tgt);
      return {6'h02, 10'h000, tgt};
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      if (a == 0) return 32'h0;
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'h22:   return 3'd1;
         6'h24:   return 3'd2;
         6'h25:   return 3'd3;
         6'h2A:   return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pcd = '0;
      pm_pc = '0;
      m_ex = '0;
      m_last_stall = 1'b0;
   endfunction

   // Reference behaviour for one cycle, given the inputs and the model state.
   task automatic model(input logic [31:0] w, input logic rst_v, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic mrw, input logic [4:0] md,
                        output comb_t c, output pkt_t p);
      logic [5:0]  opc, fn;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b;
      logic        is_r, is_beq, is_j, reads_rt, hz;
      c = '0;
      p = '0;
      if (rst_v) begin
         opc = w[31:26]; fn = w[5:0];
         rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
         a = rd_reg(rs, we, wa, wd);
         b = rd_reg(rt, we, wa, wd);
         is_r   = (opc == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
         is_beq = (opc == 6'h04);
         is_j   = (opc == 6'h02);
         reads_rt = is_r || is_beq || (opc == 6'h2B);
         hz = m_ex.mr && (m_ex.dest != 0) && ((m_ex.dest == rs) || (reads_rt && m_ex.dest == rt));
         if (is_beq) begin
            if (rs != 0 && ((m_ex.rw && rs == m_ex.dest) || (mrw && rs == md))) hz = 1'b1;
            if (rt != 0 && ((m_ex.rw && rt == m_ex.dest) || (mrw && rt == md))) hz = 1'b1;
         end
         c.stall = hz;
         if (!hz) begin
            if (is_j) begin
               c.pcsel = 1'b1;
               c.jmp = w[15:0];
            end else if (is_beq && a == b) begin
               c.pcsel = 1'b1;
               c.jmp = 16'((32'(m_pcd) + 32'd1 + 32'(w[15:0])) % 32'd65536);
            end
            p.rs = a;
            p.rt = b;
            p.imm = w[15] ? (32'(w[15:0]) - 32'h10000) : 32'(w[15:0]);
            if (is_r) begin
               p.dest = rd; p.rw = 1'b1; p.v = 1'b1; p.op = alu_of(fn);
            end else if (opc == 6'h08) begin
               p.dest = rt; p.rw = 1'b1; p.v = 1'b1;
            end else if (opc == 6'h23) begin
               p.dest = rt; p.rw = 1'b1; p.mr = 1'b1; p.v = 1'b1;
            end else if (opc == 6'h2B) begin
               p.mw = 1'b1; p.v = 1'b1;
            end else if (is_beq || is_j) begin
               p.v = 1'b1;
            end
         end
      end
   endtask

   // Drives one cycle at the falling edge, acting as the fetch stage too.
   task automatic step(input logic [31:0] w, input logic rst_v, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mrw, input logic [4:0] md);
      comb_t       c;
      pkt_t        p;
      logic [15:0] addr;
      @(negedge clk);
      model(w, rst_v, we, wa, wd, mrw, md, c, p);
      addr = !rst_v ? 16'h0 : (c.pcsel ? c.jmp : pm_pc);
      reset = rst_v; ins = w; current_address = addr;
      wb_en = we; wb_addr = wa; wb_data = wd;
      mem_reg_write = mrw; mem_dest = md;
      cq.push_back(c);
      xq.push_back(p);
      if (!rst_v) m_reset();
      else begin
         if (we && wa != 0) m_regs[wa] = wd;
         if (!c.stall) begin
            m_pcd = addr;
            pm_pc = addr + 16'd1;
         end
         m_ex = p;
         m_last_stall = c.stall;
      end
   endtask

   task automatic op(input logic [31:0] w);
      step(w, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [4:0]  s, t, d;
      logic [15:0] imm;
      s = 5'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 10))
         0, 1, 2: return rtype(s, t, d, fn_tab[$urandom_range(0, 4)]);
         3:       return rtype(s, t, d, 6'($urandom));
         4:       return itype(6'h08, s, t, imm);
         5:       return itype(6'h23, s, t, imm);
         6:       return itype(6'h2B, s, t, imm);
         7:       return itype(6'h04, s, t, 16'($urandom_range(0, 7)));
         8:       return jtype(imm);
         9:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin : comb_monitor
      comb_t c;
      forever begin
         @(negedge clk);
         #2;
         if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("stall", 32'(stall), 32'(c.stall));
            chk("stall_pm", 32'(stall_pm), 32'(c.stall));
            chk("pc_mux_sel", 32'(pc_mux_sel), 32'(c.pcsel));
            chk("jmp_loc", 32'(jmp_loc), 32'(c.jmp));
         end
      end
   end

   initial begin : idex_monitor
      pkt_t p;
      forever begin
         @(posedge clk);
         #1;
         if (xq.size() > 0) begin
            p = xq.pop_front();
            chk("ex_valid", 32'(ex_if.ex_valid), 32'(p.v));
            chk("ex_rs_data", ex_if.ex_rs_data, p.rs);
            chk("ex_rt_data", ex_if.ex_rt_data, p.rt);
            chk("ex_imm", ex_if.ex_imm, p.imm);
            chk("ex_dest", 32'(ex_if.ex_dest), 32'(p.dest));
            chk("ex_alu_op", 32'(ex_if.ex_alu_op), 32'(p.op));
            chk("ex_ctrl", 32'({ex_if.ex_reg_write, ex_if.ex_mem_read, ex_if.ex_mem_write}),
                32'({p.rw, p.mr, p.mw}));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      logic [31:0] cur;
      m_reset();
      step(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      step(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      // ADDI r1,r0,5 ; write r1=5 ; ADD r2,r1,r1
      op(itype(6'h08, 5'd0, 5'd1, 16'd5));
      step(32'h0, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0);
      op(rtype(5'd1, 5'd1, 5'd2, 6'h20));
      @(posedge clk); #1;
      chk("add_rs", ex_if.ex_rs_data, 32'd5);
      chk("add_rt", ex_if.ex_rt_data, 32'd5);
      chk("add_dest", 32'(ex_if.ex_dest), 32'd2);
      chk("add_op_rw", 32'({ex_if.ex_alu_op, ex_if.ex_reg_write}), 32'b0001);

      // load-use: LW r3 ; ADD r4,r3,r1
      op(itype(6'h23, 5'd0, 5'd3, 16'd0));
      op(rtype(5'd3, 5'd1, 5'd4, 6'h20));
      #2;
      chk("lu_stall", 32'({stall, stall_pm}), 32'b11);
      @(posedge clk); #1;
      chk("lu_bubble", 32'(ex_if.ex_valid), 32'd0);
      op(rtype(5'd3, 5'd1, 5'd4, 6'h20));
      #2;
      chk("lu_release", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("lu_issue", 32'({ex_if.ex_valid, ex_if.ex_dest}), 32'({1'b1, 5'd4}));

      // J 0x0010 ; J 0x0040 at pc_d=0x10 ; BEQ r0,r0,0 at pc_d=0x40
      op(jtype(16'h0010));
      op(jtype(16'h0040));
      #2;
      chk("j_sel", 32'(pc_mux_sel), 32'd1);
      chk("j_loc", 32'(jmp_loc), 32'h0040);
      op(itype(6'h04, 5'd0, 5'd0, 16'h0000));
      #2;
      chk("j_target_pcd", 32'(jmp_loc), 32'h0041);

      // BEQ backwards with wrap, then an untaken BEQ
      op(jtype(16'h0005));
      op(itype(6'h04, 5'd0, 5'd0, 16'hFFFE));
      #2;
      chk("beq_back", 32'({pc_mux_sel, jmp_loc}), 32'({1'b1, 16'h0004}));
      op(itype(6'h04, 5'd1, 5'd0, 16'h0003));
      #2;
      chk("beq_ne", 32'({pc_mux_sel, jmp_loc}), 32'd0);

      // BEQ r5 blocked by a MEM-stage writer of r5 for two cycles
      for (int i = 0; i < 2; i++) begin
         step(itype(6'h04, 5'd5, 5'd0, 16'h0002), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
         #2;
         chk("bh_stall", 32'({stall, pc_mux_sel}), 32'b10);
      end
      op(itype(6'h04, 5'd5, 5'd0, 16'h0002));
      #2;
      chk("bh_resolve", 32'({stall, pc_mux_sel, jmp_loc}), 32'({2'b01, 16'h0008}));

      // reset asserted in the middle of a load-use stall
      op(itype(6'h23, 5'd0, 5'd3, 16'd0));
      op(rtype(5'd3, 5'd1, 5'd4, 6'h20));
      #2;
      chk("rst_pre_stall", 32'(stall), 32'd1);
      #1;
      reset = 1'b0;
      m_reset();
      #1;
      chk("rst_ctrl", 32'({stall, stall_pm, pc_mux_sel}), 32'd0);
      chk("rst_idex", 32'({ex_if.ex_valid, ex_if.ex_reg_write, ex_if.ex_mem_read, ex_if.ex_dest}), 32'd0);
      step(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      op(32'h0);
      op(rtype(5'd1, 5'd0, 5'd2, 6'h20));
      @(posedge clk); #1;
      chk("rst_r1", ex_if.ex_rs_data, 32'd0);

      // randomized traffic; fetch stage holds ins while stalled
      cur = 32'h0;
      for (int i = 0; i < 600; i++) begin
         if (!m_last_stall) cur = rand_ins();
         step(cur, ($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      end
      op(32'h0);
      @(posedge clk); #3;
      chk("queues_drained", 32'(cq.size() + xq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
